// File: rtl/jogo_sequencia_param_pkg.sv
`default_nettype none
// ============================================================================
// jogo_sequencia_param_pkg : state codes and sequence ROM indexing
// Rev 1.0
// ============================================================================
package jogo_sequencia_param_pkg;

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARA       = 4'h1,
    INICIA_RODADA = 4'h2,
    ESPERA        = 4'h3,
    REGISTRA      = 4'h4,
    COMPARA       = 4'h5,
    PROX_JOGADA   = 4'h6,
    PROX_RODADA   = 4'h7,
    FIM_ACERTO    = 4'hA,
    FIM_TIMEOUT   = 4'hD,
    FIM_ERRO      = 4'hE
  } estado_t;

  // Bit position lit by ROM word a on an n-button board.
  function automatic int unsigned rom_idx(input int unsigned a, input int unsigned n);
    return (3 * a + 1) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jogo_sequencia_uc.sv
`default_nettype none
// ============================================================================
// jogo_sequencia_uc : game control FSM with registered Moore end-state flags
// Rev 1.0
// ============================================================================
module jogo_sequencia_uc
  import jogo_sequencia_param_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    jogar,
  input  logic    tem_jogada,
  input  logic    fim_timer,
  input  logic    igual,
  input  logic    fim_rodada,
  input  logic    ultima_rodada,
  output estado_t estado,
  output logic    pronto,
  output logic    ganhou,
  output logic    perdeu,
  output logic    timeout
);

  estado_t estado_q, estado_d;
  logic    pronto_q, ganhou_q, perdeu_q, timeout_q;

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:       if (jogar) estado_d = PREPARA;
      PREPARA:       estado_d = INICIA_RODADA;
      INICIA_RODADA: estado_d = ESPERA;
      ESPERA: begin
        // Timeout has priority over a press arriving in the same cycle.
        if (fim_timer)       estado_d = FIM_TIMEOUT;
        else if (tem_jogada) estado_d = REGISTRA;
      end
      REGISTRA:      estado_d = COMPARA;
      COMPARA: begin
        if (!igual)              estado_d = FIM_ERRO;
        else if (!fim_rodada)    estado_d = PROX_JOGADA;
        else if (ultima_rodada)  estado_d = FIM_ACERTO;
        else                     estado_d = PROX_RODADA;
      end
      PROX_JOGADA:   estado_d = ESPERA;
      PROX_RODADA:   estado_d = INICIA_RODADA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (jogar) estado_d = PREPARA;
      default:       estado_d = INICIAL;
    endcase
  end

  // Flags are decoded from the next state so they line up with estado_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= INICIAL;
      pronto_q  <= 1'b0;
      ganhou_q  <= 1'b0;
      perdeu_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      pronto_q  <= estado_d inside {FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT};
      ganhou_q  <= (estado_d == FIM_ACERTO);
      perdeu_q  <= (estado_d == FIM_ERRO) || (estado_d == FIM_TIMEOUT);
      timeout_q <= (estado_d == FIM_TIMEOUT);
    end
  end

  assign estado  = estado_q;
  assign pronto  = pronto_q;
  assign ganhou  = ganhou_q;
  assign perdeu  = perdeu_q;
  assign timeout = timeout_q;

endmodule
`default_nettype wire

// File: rtl/jogo_sequencia_param.sv
`default_nettype none
// ============================================================================
// jogo_sequencia_param : sequence-memory game top (datapath + control FSM)
// Rev 1.0
// ============================================================================
module jogo_sequencia_param
  import jogo_sequencia_param_pkg::*;
#(
  parameter int N_BOTOES       = 4,
  parameter int N_SEQ          = 16,
  parameter int TIMEOUT_CICLOS = 5000,
  localparam int AW            = $clog2(N_SEQ)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic                modo,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] leds,
  output logic                pronto,
  output logic                ganhou,
  output logic                perdeu,
  output logic                timeout,
  output logic [3:0]          db_estado,
  output logic [AW-1:0]       db_endereco,
  output logic [AW-1:0]       db_rodada,
  output logic [N_BOTOES-1:0] db_memoria,
  output logic [N_BOTOES-1:0] db_jogada,
  output logic                db_tem_jogada
);

  localparam int            TW        = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [TW-1:0] T_MAX     = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [AW-1:0] LIM_LONGO = AW'(N_SEQ - 1);
  localparam logic [AW-1:0] LIM_CURTO = AW'(N_SEQ / 2 - 1);

  estado_t             estado;
  logic [AW-1:0]       e_q, e_d, s_q, s_d;
  logic [N_BOTOES-1:0] r_q, r_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                modo_q, modo_d;
  logic                any_q;
  logic                tem_jogada;
  logic [N_BOTOES-1:0] memoria;
  logic [AW-1:0]       limite;

  // A play is only the rising edge of "any button down".
  assign tem_jogada = (|botoes) & ~any_q;
  assign limite     = modo_q ? LIM_CURTO : LIM_LONGO;

  for (genvar g = 0; g < N_BOTOES; g++) begin : g_rom
    assign memoria[g] = (rom_idx(32'(e_q), N_BOTOES) == g);
  end

  always_comb begin
    e_d     = e_q;
    s_d     = s_q;
    r_d     = r_q;
    modo_d  = modo_q;
    timer_d = '0;
    case (estado)
      PREPARA: begin
        e_d    = '0;
        s_d    = '0;
        r_d    = '0;
        modo_d = modo;
      end
      INICIA_RODADA: e_d     = '0;
      ESPERA:        timer_d = timer_q + 1'b1;
      REGISTRA:      r_d     = botoes;
      PROX_JOGADA:   e_d     = e_q + 1'b1;
      PROX_RODADA:   s_d     = s_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      e_q     <= '0;
      s_q     <= '0;
      r_q     <= '0;
      timer_q <= '0;
      modo_q  <= 1'b0;
    end else begin
      e_q     <= e_d;
      s_q     <= s_d;
      r_q     <= r_d;
      timer_q <= timer_d;
      modo_q  <= modo_d;
    end
    any_q <= |botoes;
  end

  jogo_sequencia_uc u_uc (
    .clock         (clock),
    .reset         (reset),
    .jogar         (jogar),
    .tem_jogada    (tem_jogada),
    .fim_timer     (timer_q == T_MAX),
    .igual         (r_q == memoria),
    .fim_rodada    (e_q == s_q),
    .ultima_rodada (s_q == limite),
    .estado        (estado),
    .pronto        (pronto),
    .ganhou        (ganhou),
    .perdeu        (perdeu),
    .timeout       (timeout)
  );

  assign leds          = botoes;
  assign db_estado     = estado;
  assign db_endereco   = e_q;
  assign db_rodada     = s_q;
  assign db_memoria    = memoria;
  assign db_jogada     = r_q;
  assign db_tem_jogada = tem_jogada;

endmodule
`default_nettype wire

// File: tb/tb_jogo_sequencia_param.sv
`default_nettype none
// ============================================================================
// tb_jogo_sequencia_param : directed game scenarios against a behavioural model
// Rev 1.0
// ============================================================================
module tb_jogo_sequencia_param;

  localparam int NB = 4;
  localparam int NS = 4;
  localparam int TO = 20;
  localparam int AW = $clog2(NS);

  logic          clock = 1'b0;
  logic          reset, jogar, modo;
  logic [NB-1:0] botoes;
  logic [NB-1:0] leds, db_memoria, db_jogada;
  logic          pronto, ganhou, perdeu, timeout, db_tem_jogada;
  logic [3:0]    db_estado;
  logic [AW-1:0] db_endereco, db_rodada;

  int checks = 0;
  int errors = 0;

  // Model state: game phase code, address, round, play register, timer, mode, last "any".
  int mst = 0, me = 0, ms = 0, mr = 0, mt = 0, mmodo = 0;
  bit many = 1'b0;

  logic [NB-1:0] seq [NS] = '{4'b0010, 4'b0001, 4'b1000, 4'b0100};

  always #5 clock = ~clock;

  jogo_sequencia_param #(.N_BOTOES(NB), .N_SEQ(NS), .TIMEOUT_CICLOS(TO)) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .modo(modo), .botoes(botoes),
    .leds(leds), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout),
    .db_estado(db_estado), .db_endereco(db_endereco), .db_rodada(db_rodada),
    .db_memoria(db_memoria), .db_jogada(db_jogada), .db_tem_jogada(db_tem_jogada)
  );

  function automatic int word(input int a);
    return 1 << ((3 * a + 1) % NB);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advance on each edge, then compare every output shortly after.
  always @(posedge clock) begin
    int nst, ne, ns, nr, nt, nm, lim, tem;
    if (reset) begin
      mst = 0; me = 0; ms = 0; mr = 0; mt = 0; mmodo = 0;
    end else begin
      lim = (mmodo != 0) ? NS / 2 - 1 : NS - 1;
      tem = (botoes != 0 && !many) ? 1 : 0;
      nst = mst; ne = me; ns = ms; nr = mr; nt = 0; nm = mmodo;
      case (mst)
        0:  if (jogar) nst = 1;
        1:  begin ne = 0; ns = 0; nr = 0; nm = int'(modo); nst = 2; end
        2:  begin ne = 0; nst = 3; end
        3:  begin
              nt = mt + 1;
              if (mt == TO - 1) nst = 13;
              else if (tem != 0) nst = 4;
            end
        4:  begin nr = int'(botoes); nst = 5; end
        5:  begin
              if (mr != word(me)) nst = 14;
              else if (me != ms)  nst = 6;
              else if (ms == lim) nst = 10;
              else                nst = 7;
            end
        6:  begin ne = me + 1; nst = 3; end
        7:  begin ns = ms + 1; nst = 2; end
        10, 13, 14: if (jogar) nst = 1;
        default: nst = 0;
      endcase
      mst = nst; me = ne; ms = ns; mr = nr; mt = nt; mmodo = nm;
    end
    many = (botoes != 0);
    #4;
    chk("estado",   int'(db_estado),     mst);
    chk("endereco", int'(db_endereco),   me);
    chk("rodada",   int'(db_rodada),     ms);
    chk("jogada",   int'(db_jogada),     mr);
    chk("memoria",  int'(db_memoria),    word(me));
    chk("leds",     int'(leds),          int'(botoes));
    chk("tem",      int'(db_tem_jogada), (botoes != 0 && !many) ? 1 : 0);
    chk("pronto",   int'(pronto),  (mst == 10 || mst == 13 || mst == 14) ? 1 : 0);
    chk("ganhou",   int'(ganhou),  (mst == 10) ? 1 : 0);
    chk("perdeu",   int'(perdeu),  (mst == 13 || mst == 14) ? 1 : 0);
    chk("timeout",  int'(timeout), (mst == 13) ? 1 : 0);
  end

  task automatic wait_state(input int code, input int budget, input string name);
    for (int i = 0; i < budget && int'(db_estado) != code; i++) @(negedge clock);
    chk(name, int'(db_estado), code);
  endtask

  task automatic start_game();
    jogar = 1'b1;
    @(negedge clock);
    jogar = 1'b0;
  endtask

  task automatic press(input logic [NB-1:0] p);
    wait_state(3, 40, "reach_espera");
    botoes = p;
    repeat (3) @(negedge clock);
    botoes = '0;
    @(negedge clock);
  endtask

  initial begin
    int nreg;
    reset = 1'b1; jogar = 1'b0; modo = 1'b0; botoes = '0;
    repeat (2) @(negedge clock);
    chk("rst_estado", int'(db_estado), 0);
    chk("rst_flags", int'({pronto, ganhou, perdeu, timeout}), 0);
    chk("rst_e_s", int'({db_endereco, db_rodada}), 0);
    reset = 1'b0;
    @(negedge clock);

    // Full win, four rounds.
    start_game();
    for (int r = 0; r < NS; r++)
      for (int a = 0; a <= r; a++) press(seq[a]);
    wait_state(4'hA, 10, "win_state");
    chk("win_flags", int'({pronto, ganhou, perdeu, timeout}), 4'b1100);

    // Wrong second play in round 1.
    start_game();
    press(seq[0]);
    press(seq[0]);
    press(4'b1000);
    wait_state(4'hE, 10, "err_state");
    chk("err_flags", int'({pronto, ganhou, perdeu, timeout}), 4'b1010);
    chk("err_e", int'(db_endereco), 1);
    chk("err_s", int'(db_rodada), 1);

    // Silent timeout: 20 cycles in ESPERA.
    start_game();
    wait_state(3, 10, "to_espera");
    repeat (TO - 1) @(negedge clock);
    chk("to_still_espera", int'(db_estado), 3);
    @(negedge clock);
    chk("to_state", int'(db_estado), 4'hD);
    chk("to_flags", int'({pronto, ganhou, perdeu, timeout}), 4'b1011);

    // Press landing on the last timer cycle still times out.
    start_game();
    wait_state(3, 10, "to2_espera");
    repeat (TO - 1) @(negedge clock);
    botoes = 4'b0001;
    @(negedge clock);
    chk("to2_state", int'(db_estado), 4'hD);
    botoes = '0;
    @(negedge clock);

    // Short mode: two rounds; mid-game modo change ignored.
    modo = 1'b1;
    start_game();
    press(seq[0]);
    modo = 1'b0;
    press(seq[0]);
    press(seq[1]);
    wait_state(4'hA, 10, "short_win");
    chk("short_rodada", int'(db_rodada), 1);
    chk("short_ganhou", int'(ganhou), 1);

    // Held button registers once (and then times out), multi-bit press mismatches.
    start_game();
    wait_state(3, 10, "hold_espera");
    botoes = seq[0];
    nreg = 0;
    repeat (30) begin
      @(negedge clock);
      if (db_estado == 4'h4) nreg++;
    end
    botoes = '0;
    chk("hold_registra_count", nreg, 1);
    chk("hold_timeout", int'(db_estado), 4'hD);
    start_game();
    press(4'b0011);
    wait_state(4'hE, 10, "multi_err");
    chk("multi_jogada", int'(db_jogada), 4'b0011);

    // Mid-game reset, then restart straight from FIM_ERRO.
    start_game();
    press(seq[0]);
    press(seq[0]);
    press(seq[1]);
    wait_state(3, 10, "r2_espera");
    chk("r2_rodada", int'(db_rodada), 2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_estado", int'(db_estado), 0);
    chk("midrst_e_s", int'({db_endereco, db_rodada}), 0);
    chk("midrst_flags", int'({pronto, ganhou, perdeu, timeout}), 0);
    start_game();
    press(4'b1000);
    wait_state(4'hE, 10, "rst_err");
    jogar = 1'b1;
    @(negedge clock);
    jogar = 1'b0;
    chk("restart_estado", int'(db_estado), 1);
    chk("restart_flags", int'({pronto, perdeu}), 0);

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
